// File: rtl/jpeg_axi_pkg.sv
// Shared register map, control/status bit positions and FSM state type for the
// JPEG colour-space-conversion AXI-Lite front-end.
package jpeg_axi_pkg;

  // Word indices (byte address bits [3:2])
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegPixIn  = 2'd2;
  localparam logic [1:0] RegResOut = 2'd3;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlIrqEn   = 1;
  localparam int unsigned CtrlSoftRst = 2;

  localparam int unsigned StatBusy  = 0;
  localparam int unsigned StatDone  = 1;
  localparam int unsigned StatError = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/jpeg_pix_buf.sv
// Depth x width register array with one synchronous write port and one
// asynchronous read port; holds either input pixels or conversion results.
module jpeg_pix_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jpeg_csc_axi_ctrl.sv
// AXI4-Lite front-end owning one block of pixels for a CSC core: software fills the
// input buffer, starts the job, and pops converted results after DONE/IRQ.
module jpeg_csc_axi_ctrl
  import jpeg_axi_pkg::*;
#(
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 4,
  parameter int unsigned INPUT_WIDTH          = 8,
  parameter int unsigned OUTPUT_WIDTH         = 8,
  parameter int unsigned PIXEL_COUNT          = 64,
  parameter int unsigned CNT_W                = $clog2(PIXEL_COUNT + 1)
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic [3*INPUT_WIDTH-1:0]            pix_data,
  input  logic                                res_valid,
  input  logic [3*OUTPUT_WIDTH-1:0]           res_data,
  output logic                                res_ready,
  output logic                                core_srst,
  output logic                                jpeg_irq
);

  localparam int unsigned DW     = C_S00_AXI_DATA_WIDTH;
  localparam int unsigned PW     = 3 * INPUT_WIDTH;
  localparam int unsigned RW     = 3 * OUTPUT_WIDTH;
  localparam int unsigned BUF_AW = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(PIXEL_COUNT);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(PIXEL_COUNT - 1);

  state_e state_q;
  logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0] rdata_q, rd_mux;
  logic pix_valid_q, res_ready_q, core_srst_q, irq_q, irq_en_q, done_q, error_q;
  logic [CNT_W-1:0] in_cnt_q, res_cnt_q, send_ptr_q, rd_ptr_q;
  logic [RW-1:0] res_rd;

  logic wr_en, wr_do, rd_en, busy, pix_fire, res_fire;
  logic ctrl_wr, stat_wr, start_req, srst_req, push_req, pop_req;
  logic start_ok, push_ok, pop_ok, err_set;
  logic [1:0] wr_idx, rd_idx;

  assign wr_en    = awready_q & s00_axi_awvalid & wready_q & s00_axi_wvalid;
  assign wr_do    = wr_en & (|s00_axi_wstrb);
  assign rd_en    = arready_q & s00_axi_arvalid;
  assign wr_idx   = s00_axi_awaddr[3:2];
  assign rd_idx   = s00_axi_araddr[3:2];
  assign busy     = (state_q == StStream) || (state_q == StDrain);
  assign pix_fire = pix_valid_q & pix_ready;
  assign res_fire = res_ready_q & res_valid;

  assign ctrl_wr   = wr_do && (wr_idx == RegCtrl);
  assign stat_wr   = wr_do && (wr_idx == RegStatus);
  assign start_req = ctrl_wr & s00_axi_wdata[CtrlStart];
  assign srst_req  = ctrl_wr & s00_axi_wdata[CtrlSoftRst];
  assign push_req  = wr_do && (wr_idx == RegPixIn);
  assign pop_req   = rd_en && (rd_idx == RegResOut);
  assign start_ok  = start_req & ~busy & (in_cnt_q == CntFull);
  assign push_ok   = push_req & ~busy & (in_cnt_q != CntFull);
  assign pop_ok    = pop_req & ~busy & (rd_ptr_q != res_cnt_q);
  assign err_set   = (start_req & ~start_ok) | (push_req & ~push_ok) | (pop_req & ~pop_ok);

  jpeg_pix_buf #(.DEPTH(PIXEL_COUNT), .WIDTH(PW), .AW(BUF_AW)) u_in_buf (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .we    (push_ok & ~srst_req),
    .waddr (in_cnt_q[BUF_AW-1:0]),
    .wdata (s00_axi_wdata[PW-1:0]),
    .raddr (send_ptr_q[BUF_AW-1:0]),
    .rdata (pix_data)
  );

  jpeg_pix_buf #(.DEPTH(PIXEL_COUNT), .WIDTH(RW), .AW(BUF_AW)) u_res_buf (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .we    (res_fire),
    .waddr (res_cnt_q[BUF_AW-1:0]),
    .wdata (res_data),
    .raddr (rd_ptr_q[BUF_AW-1:0]),
    .rdata (res_rd)
  );

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      RegCtrl:   rd_mux[CtrlIrqEn] = irq_en_q;
      RegStatus: begin
        rd_mux[StatBusy]  = busy;
        rd_mux[StatDone]  = done_q;
        rd_mux[StatError] = error_q;
        rd_mux[15:8]      = 8'(in_cnt_q);
        rd_mux[23:16]     = 8'(res_cnt_q);
      end
      RegResOut: if (pop_ok) rd_mux[RW-1:0] = res_rd;
      default:   ;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= ~awready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
      wready_q  <= ~awready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
      if (wr_en) bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;
      arready_q <= ~arready_q & s00_axi_arvalid & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q     <= StIdle;
      pix_valid_q <= 1'b0;
      res_ready_q <= 1'b0;
      core_srst_q <= 1'b0;
      irq_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      in_cnt_q    <= '0;
      res_cnt_q   <= '0;
      send_ptr_q  <= '0;
      rd_ptr_q    <= '0;
    end else begin
      core_srst_q <= srst_req;
      irq_q       <= done_q & irq_en_q;
      if (ctrl_wr) irq_en_q <= s00_axi_wdata[CtrlIrqEn];
      if (srst_req) begin
        state_q     <= StIdle;
        pix_valid_q <= 1'b0;
        res_ready_q <= 1'b0;
        done_q      <= 1'b0;
        error_q     <= 1'b0;
        in_cnt_q    <= '0;
        res_cnt_q   <= '0;
        send_ptr_q  <= '0;
        rd_ptr_q    <= '0;
      end else begin
        // A new error outranks a simultaneous W1C from the write channel
        if (err_set) error_q <= 1'b1;
        else if (stat_wr && s00_axi_wdata[StatError]) error_q <= 1'b0;
        if (stat_wr && s00_axi_wdata[StatDone]) done_q <= 1'b0;
        if (push_ok) in_cnt_q <= in_cnt_q + CntOne;
        if (pop_ok) rd_ptr_q <= rd_ptr_q + CntOne;
        unique case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q     <= StStream;
              pix_valid_q <= 1'b1;
              res_ready_q <= 1'b1;
              done_q      <= 1'b0;
              res_cnt_q   <= '0;
              send_ptr_q  <= '0;
              rd_ptr_q    <= '0;
            end
          end
          StStream, StDrain: begin
            if (pix_fire) send_ptr_q <= send_ptr_q + CntOne;
            if (res_fire) res_cnt_q <= res_cnt_q + CntOne;
            if (res_fire && (res_cnt_q == CntLast)) begin
              state_q     <= StDone;
              pix_valid_q <= 1'b0;
              res_ready_q <= 1'b0;
              done_q      <= 1'b1;
              in_cnt_q    <= '0;
            end else if (pix_fire && (send_ptr_q == CntLast)) begin
              state_q     <= StDrain;
              pix_valid_q <= 1'b0;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  logic unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                    s00_axi_wdata};

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign pix_valid       = pix_valid_q;
  assign res_ready       = res_ready_q;
  assign core_srst       = core_srst_q;
  assign jpeg_irq        = irq_q;

endmodule

// File: tb/tb_jpeg_csc_axi_ctrl.sv
// Bench for jpeg_csc_axi_ctrl: AXI-Lite driver, 3-cycle identity CSC core model and a
// queue scoreboard of expected RES_OUT words filled as pixels are pushed.
module tb_jpeg_csc_axi_ctrl;
  import jpeg_axi_pkg::*;

  localparam int PC = 64;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        pix_valid, pix_ready, res_valid, res_ready, core_srst, jpeg_irq;
  logic [23:0] pix_data, res_data;

  always #5 clk = ~clk;

  jpeg_csc_axi_ctrl #(
    .C_S00_AXI_DATA_WIDTH (32),
    .C_S00_AXI_ADDR_WIDTH (4),
    .INPUT_WIDTH          (8),
    .OUTPUT_WIDTH         (8),
    .PIXEL_COUNT          (PC)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (aresetn),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .res_ready       (res_ready),
    .core_srst       (core_srst),
    .jpeg_irq        (jpeg_irq)
  );

  // Core model: Y=R, Cb=G, Cr=B, three-cycle latency, flushed by core_srst
  logic        toggle_mode;
  logic [2:0]  pv;
  logic [23:0] pd0, pd1, pd2;
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pv        <= '0;
      pix_ready <= 1'b1;
    end else begin
      pix_ready <= toggle_mode ? ~pix_ready : 1'b1;
      if (core_srst) begin
        pv <= '0;
      end else begin
        pv  <= {pv[1:0], pix_valid & pix_ready};
        pd0 <= pix_data;
        pd1 <= pd0;
        pd2 <= pd1;
      end
    end
  end
  assign res_valid = pv[2];
  assign res_data  = {pd2[23:16], pd2[15:8], pd2[7:0]};

  int busy_cycles = 0, sent_cnt = 0, srst_cnt = 0;
  always @(negedge clk) begin
    if (res_ready) busy_cycles++;
    if (pix_valid && pix_ready) sent_cnt++;
    if (core_srst) srst_cnt++;
  end

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb = 4'hf);
    logic ok;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("aw_handshake", {31'd0, ok}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) check_eq("b_response", {31'd0, ok}, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    logic ok;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq("ar_handshake", {31'd0, ok}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    ok = 1'b0;
    data = 32'hdead_beef;
    for (int n = 0; n < 20; n++) begin
      if (rvalid) begin ok = 1'b1; data = rdata; break; end
      @(negedge clk);
    end
    if (!ok) check_eq("r_response", {31'd0, ok}, 32'd1);
  endtask

  function automatic logic [23:0] pix_pat(input int set, input int i);
    logic [7:0] r, g, b;
    case (set)
      0:       begin r = 8'(i);          g = 8'(2 * i);     b = 8'(255 - i); end
      1:       begin r = 8'(i ^ 'h5a);   g = 8'(i + 100);   b = 8'(3 * i);   end
      2:       begin r = 8'(200 - i);    g = 8'(i ^ 'hc3);  b = 8'(i);       end
      default: begin r = 8'(i + 7);      g = 8'(255 - 2*i); b = 8'(5 * i);   end
    endcase
    return {b, g, r};
  endfunction

  task automatic push_pixels(input int set, input int from, input int to);
    logic [23:0] p;
    for (int i = from; i < to; i++) begin
      p = pix_pat(set, i);
      axi_write({RegPixIn, 2'b00}, {8'h00, p});
      exp_q.push_back({8'h00, p[23:16], p[15:8], p[7:0]});
    end
  endtask

  task automatic read_results(input int n, input string tag);
    logic [31:0] d, e;
    for (int i = 0; i < n; i++) begin
      axi_read({RegResOut, 2'b00}, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
      check_eq(tag, d, e);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!res_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_eq(tag, {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] d;
  int base;

  initial begin
    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b1;
    arvalid = 1'b0; rready = 1'b1; toggle_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {23'd0, awready, wready, bvalid, arready, rvalid, pix_valid,
             res_ready, core_srst, jpeg_irq}, 32'd0);
    check_eq("reset_resp_rdata", rdata | {28'd0, bresp, rresp}, 32'd0);
    aresetn = 1'b1;

    axi_read({RegStatus, 2'b00}, d); check_eq("reset_status", d, 32'h0);
    axi_read({RegCtrl, 2'b00}, d);   check_eq("reset_ctrl", d, 32'h0);

    // Basic job
    axi_write({RegCtrl, 2'b00}, 32'h2);
    axi_write({RegCtrl, 2'b00}, 32'h0, 4'h0);
    axi_read({RegCtrl, 2'b00}, d);   check_eq("ctrl_wstrb0_ignored", d, 32'h2);
    push_pixels(0, 0, PC);
    base = busy_cycles;
    axi_write({RegCtrl, 2'b00}, 32'h3);
    wait_idle("job1_timeout");
    check_eq("job1_busy_ge66", {31'd0, (busy_cycles - base) >= 66}, 32'd1);
    check_eq("job1_irq", {31'd0, jpeg_irq}, 32'd1);
    axi_read({RegStatus, 2'b00}, d); check_eq("job1_status", d, 32'h0040_0002);
    read_results(PC, "job1_res");

    // Premature START
    push_pixels(1, 0, 10);
    axi_write({RegCtrl, 2'b00}, 32'h3);
    axi_read({RegStatus, 2'b00}, d); check_eq("short_start_status", d, 32'h0040_0a06);
    axi_write({RegStatus, 2'b00}, 32'h4);
    axi_read({RegStatus, 2'b00}, d); check_eq("error_w1c", d, 32'h0040_0a02);

    // Back-pressured job with an illegal push while streaming
    toggle_mode = 1'b1;
    push_pixels(1, 10, PC);
    axi_write({RegCtrl, 2'b00}, 32'h3);
    axi_write({RegPixIn, 2'b00}, 32'h00ab_cdef);
    wait_idle("job2_timeout");
    check_eq("job2_irq", {31'd0, jpeg_irq}, 32'd1);
    axi_read({RegStatus, 2'b00}, d); check_eq("job2_status", d, 32'h0040_0006);
    read_results(PC, "job2_res");
    axi_write({RegStatus, 2'b00}, 32'h4);
    toggle_mode = 1'b0;

    // Soft reset mid-stream, then a clean job
    push_pixels(2, 0, PC);
    axi_write({RegCtrl, 2'b00}, 32'h3);
    base = sent_cnt;
    for (int n = 0; n < 200; n++) begin
      if (sent_cnt - base >= 20) break;
      @(negedge clk);
    end
    base = srst_cnt;
    axi_write({RegCtrl, 2'b00}, 32'h6);
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_eq("srst_pulse_count", 32'(srst_cnt - base), 32'd1);
    check_eq("srst_core_idle", {30'd0, pix_valid, res_ready}, 32'd0);
    axi_read({RegStatus, 2'b00}, d); check_eq("srst_status", d, 32'h0);
    axi_read({RegCtrl, 2'b00}, d);   check_eq("srst_irq_en_kept", d, 32'h2);
    push_pixels(3, 0, PC);
    axi_write({RegCtrl, 2'b00}, 32'h3);
    wait_idle("job3_timeout");
    check_eq("job3_irq", {31'd0, jpeg_irq}, 32'd1);
    axi_read({RegStatus, 2'b00}, d); check_eq("job3_status", d, 32'h0040_0002);
    read_results(PC, "job3_res");

    // Over-read and DONE clear
    axi_read({RegResOut, 2'b00}, d); check_eq("overread_data", d, 32'h0);
    axi_read({RegStatus, 2'b00}, d); check_eq("overread_status", d, 32'h0040_0006);
    axi_write({RegStatus, 2'b00}, 32'h2);
    @(negedge clk);
    check_eq("irq_after_done_clear", {31'd0, jpeg_irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
